// File: rtl/fpcvt_ret_queue.sv
// fpcvt_ret_queue
// Return queue between the FP->int convert stage and the integer writeback
// port. Results, their alternate/exception flag and destination register tag
// are held in a circular buffer. The head entry is presented
// first-word-fall-through. There is no same-cycle bypass, so a pushed entry
// becomes visible one cycle after the push.
//
// Ports
//   clk      single clock, all state updates on posedge
//   rst      synchronous active-low reset
//   in_en    convert result valid this cycle
//   in_res   65-bit conversion result
//   in_alt   alternate/exception flag travelling with in_res
//   in_reg   9-bit destination register tag
//   flush    discard all queued and incoming entries
//   out_rdy  writeback accepts the head entry
//   out_en   head entry valid
//   out_res  head result (zero when empty)
//   out_alt  head alternate flag (zero when empty)
//   out_reg  head register tag (zero when empty)
//   stall    back-pressure to the convert-op scheduler
//   count    number of occupied entries
//   ovf      sticky: a result was dropped because the queue was full
module fpcvt_ret_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_en,
  input  logic [64:0] in_res,
  input  logic        in_alt,
  input  logic [8:0]  in_reg,
  input  logic        flush,
  input  logic        out_rdy,
  output logic        out_en,
  output logic [64:0] out_res,
  output logic        out_alt,
  output logic [8:0]  out_reg,
  output logic        stall,
  output logic [3:0]  count,
  output logic        ovf
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [64:0]   mem_res [DEPTH];
  logic          mem_alt [DEPTH];
  logic [8:0]    mem_reg [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          pop;
  logic          push;
  logic          drop;

  // A flush ignores out_rdy, so no pop is counted in a flush cycle.
  assign pop  = out_en && out_rdy && !flush;
  // When full, a pop in the same cycle frees the slot the new entry takes.
  assign push = in_en && !flush && ((count < DEPTH_C) || pop);
  assign drop = in_en && !flush && (count == DEPTH_C) && !pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + 4'd1;
      else if (pop && !push) count <= count - 4'd1;
      if (drop) ovf <= 1'b1;
    end
  end

  // Storage is not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_res[wr_ptr] <= in_res;
      mem_alt[wr_ptr] <= in_alt;
      mem_reg[wr_ptr] <= in_reg;
    end
  end

  assign out_en  = (count != 4'd0);
  assign out_res = out_en ? mem_res[rd_ptr] : '0;
  assign out_alt = out_en ? mem_alt[rd_ptr] : 1'b0;
  assign out_reg = out_en ? mem_reg[rd_ptr] : '0;

  // One entry of slack for a result already inside the convert pipeline.
  assign stall = (count >= (DEPTH_C - 4'd1));

endmodule

// File: tb/tb_fpcvt_ret_queue.sv
// Directed bench for fpcvt_ret_queue (DEPTH=4). Inputs change 1ns after the
// rising edge, and outputs are sampled at that same point.
module tb_fpcvt_ret_queue;

  logic        clk;
  logic        rst;
  logic        in_en;
  logic [64:0] in_res;
  logic        in_alt;
  logic [8:0]  in_reg;
  logic        flush;
  logic        out_rdy;
  logic        out_en;
  logic [64:0] out_res;
  logic        out_alt;
  logic [8:0]  out_reg;
  logic        stall;
  logic [3:0]  count;
  logic        ovf;

  int nvec = 0;
  int nerr = 0;

  fpcvt_ret_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_res(in_res), .in_alt(in_alt),
    .in_reg(in_reg), .flush(flush), .out_rdy(out_rdy), .out_en(out_en),
    .out_res(out_res), .out_alt(out_alt), .out_reg(out_reg), .stall(stall),
    .count(count), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [64:0] got,
                          input logic [64:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_en   = 1'b0;
    flush   = 1'b0;
    out_rdy = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic push_one(input logic [8:0] r);
    in_en  = 1'b1;
    in_reg = r;
    in_res = {56'h0, r};
    in_alt = r[0];
    tick();
    in_en  = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check_eq({tag, "_out_en"},  out_en,  0);
    check_eq({tag, "_out_res"}, out_res, 0);
    check_eq({tag, "_out_alt"}, out_alt, 0);
    check_eq({tag, "_out_reg"}, out_reg, 0);
    check_eq({tag, "_count"},   count,   0);
    check_eq({tag, "_stall"},   stall,   0);
    check_eq({tag, "_ovf"},     ovf,     0);
  endtask

  initial begin
    rst = 1'b0; in_res = '0; in_alt = 1'b0; in_reg = '0;
    idle();
    tick();

    // Reset state
    do_reset();
    check_empty("rst");

    // First push: visible only in the following cycle
    in_en  = 1'b1;
    in_res = 65'h1_0000_0000_0000_0042;
    in_reg = 9'h1A3;
    in_alt = 1'b1;
    #2;
    check_eq("nobypass_out_en", out_en, 0);
    tick();
    in_en = 1'b0;
    check_eq("first_out_en",  out_en,  1);
    check_eq("first_out_res", out_res, 65'h1_0000_0000_0000_0042);
    check_eq("first_out_reg", out_reg, 9'h1A3);
    check_eq("first_out_alt", out_alt, 1);
    check_eq("first_count",   count,   1);
    check_eq("first_stall",   stall,   0);

    // Fill to DEPTH, stall from count 3, then overflow drop
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_one(9'(i));
      check_eq("fill_count", count, i + 1);
      check_eq("fill_stall", stall, (i + 1 >= 3) ? 1 : 0);
    end
    check_eq("fill_ovf", ovf, 0);
    push_one(9'h055);
    check_eq("drop_count", count, 4);
    check_eq("drop_ovf",   ovf,   1);
    check_eq("drop_head",  out_reg, 9'h000);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_reg", out_reg, i);
      check_eq("drain_res", out_res, i);
      check_eq("drain_alt", out_alt, i & 1);
      tick();
      check_eq("drain_count", count, 3 - i);
    end
    out_rdy = 1'b0;
    check_eq("drain_out_en", out_en, 0);
    check_eq("drain_ovf_sticky", ovf, 1);

    // Full queue with simultaneous push and pop, across pointer wrap
    do_reset();
    for (int i = 0; i < 4; i++) push_one(9'(i));
    out_rdy = 1'b1;
    for (int i = 4; i < 10; i++) begin
      check_eq("pp_head", out_reg, i - 4);
      in_en  = 1'b1;
      in_reg = 9'(i);
      in_res = {56'h0, 9'(i)};
      in_alt = in_reg[0];
      tick();
      check_eq("pp_count", count, 4);
      check_eq("pp_ovf",   ovf,   0);
    end
    in_en = 1'b0;
    for (int i = 6; i < 10; i++) begin
      check_eq("pp_drain_reg", out_reg, i);
      tick();
    end
    out_rdy = 1'b0;
    check_eq("pp_drain_empty", out_en, 0);

    // Three queued plus incoming entry under flush
    do_reset();
    for (int i = 0; i < 3; i++) push_one(9'h100 + 9'(i));
    in_en   = 1'b1;
    in_reg  = 9'h0AA;
    out_rdy = 1'b1;
    flush   = 1'b1;
    tick();
    idle();
    check_empty("flush3");
    tick();
    check_eq("flush3_still_empty", count, 0);

    // Flush also clears sticky ovf
    for (int i = 0; i < 5; i++) push_one(9'(i));
    check_eq("preflush_ovf", ovf, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_ovf",   ovf,   0);
    check_eq("flush_count", count, 0);

    // Streaming: push and pop every cycle
    do_reset();
    in_en   = 1'b1;
    out_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_reg = 9'h040 + 9'(i);
      in_res = {56'h0, in_reg};
      in_alt = in_reg[0];
      tick();
      check_eq("stream_count", count, 1);
      check_eq("stream_reg",   out_reg, 9'h040 + 9'(i));
    end
    in_en = 1'b0;
    check_eq("stream_ovf", ovf, 0);
    tick();
    out_rdy = 1'b0;
    check_eq("stream_end_count", count, 0);

    // Reset mid-operation with out_rdy held
    do_reset();
    push_one(9'h011);
    push_one(9'h022);
    check_eq("prerst_count", count, 2);
    out_rdy = 1'b1;
    rst     = 1'b0;
    tick();
    check_empty("midrst");
    rst = 1'b1;
    tick();
    check_eq("postrst_count",  count,  0);
    check_eq("postrst_out_en", out_en, 0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fpcvt_ret_queue.md
FPCVT_RET_QUEUE -- requirements
Module: fpcvt_ret_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queue entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_en  input  1  FP-to-int conversion result valid this cycle.
REQ-005 SHALL have port in_res  input  65  conversion result from the FP->int convert stage.
REQ-006 SHALL have port in_alt  input  1  alternate/exception flag accompanying in_res.
REQ-007 SHALL have port in_reg  input  9  destination integer register tag.
REQ-008 SHALL have port flush  input  1  pipeline flush; discards all queued and incoming entries.
REQ-009 SHALL have port out_rdy  input  1  integer writeback port accepts the head entry.
REQ-010 SHALL have port out_en  output  1  head entry valid.
REQ-011 SHALL have port out_res  output  65  head entry result.
REQ-012 SHALL have port out_alt  output  1  head entry alternate flag.
REQ-013 SHALL have port out_reg  output  9  head entry register tag.
REQ-014 SHALL have port stall  output  1  back-pressure to the convert-op scheduler.
REQ-015 SHALL have port count  output  4  number of occupied entries.
REQ-016 SHALL have port ovf  output  1  sticky overflow: a result was dropped.

Function
REQ-017 SHALL store entries {in_res,in_alt,in_reg} in a circular buffer of DEPTH entries with write and read pointers wrapping modulo DEPTH.
REQ-018 SHALL define pop = out_en && out_rdy; push = in_en && !flush && (count<DEPTH || pop).
REQ-019 SHALL, on push, write the entry at the write pointer and advance it by 1 at the clock edge.
REQ-020 SHALL, on pop, advance the read pointer by 1 at the clock edge.
REQ-021 SHALL update count by +1 for push only, -1 for pop only, unchanged for both or neither.
REQ-022 SHALL present the head entry first-word-fall-through: out_en = (count!=0); out_res/out_alt/out_reg driven from the entry at the read pointer; zero when count==0.
REQ-023 SHALL make a pushed entry visible on out_en no earlier than the cycle after push (no same-cycle bypass when empty).
REQ-024 SHALL accept push and pop in the same cycle when full (DEPTH entries): head leaves, new entry enters, count stays DEPTH.
REQ-025 SHALL drop in_en when full and no pop that cycle, and set ovf to 1 at that edge; ovf remains 1 until reset or flush.
REQ-026 SHALL drive stall = (count >= DEPTH-1), giving one cycle of slack for a result already in the convert pipeline.
REQ-027 SHALL on flush: clear both pointers, count and ovf at the clock edge, ignore in_en that cycle, and ignore out_rdy (no pop counted); out_en is 0 the following cycle.
REQ-028 SHALL preserve strict FIFO order of results; in_alt and in_reg travel with their in_res unchanged.
REQ-029 SHALL not change stored entry contents other than by push.

Reset
REQ-030 SHALL, when rst==0 at a clock edge, set pointers to 0, count=0, ovf=0, hence out_en=0, out_res=0, out_alt=0, out_reg=0, stall=0 (for DEPTH>=2).
REQ-031 SHALL give reset priority over flush, push and pop; reset asserted mid-operation discards all entries.
REQ-032 SHALL not require storage-array contents to be reset.

Verification
REQ-033 SHALL cover: reset, then in_en=1 with in_res=65'h1_0000_0000_0000_0042, in_reg=9'h1A3, out_rdy=0 -> next cycle out_en=1, out_res=...0042, out_reg=1A3, count=1.
REQ-034 SHALL cover: DEPTH=4, four pushes with out_rdy=0 -> count=4, stall=1 from count=3 onward; fifth push -> dropped, ovf=1, count=4.
REQ-035 SHALL cover: full queue, in_en=1 and out_rdy=1 same cycle -> head popped, new entry appended, count=4, ovf=0, order preserved across pointer wrap.
REQ-036 SHALL cover: three queued entries plus in_en=1 and flush=1 -> next cycle count=0, out_en=0, ovf=0, incoming entry absent.
REQ-037 SHALL cover: continuous in_en=1, out_rdy=1 for 20 cycles with incrementing in_reg -> out_reg sequence identical and in order, count settles at 1, no ovf.
REQ-038 SHALL cover: rst=0 asserted with two entries queued and out_rdy=1 -> next cycle all outputs 0, no pop observed after reset.
